pc_redirect_ctrl: RTL

Parametrised program-counter owner for the front end: holds the fetch PC, advances it on each accepted fetch, and arbitrates up to NSRC redirect requests from different pipeline stages with fixed priority. For each accepted redirect it drives per-stage flushes and an epoch tag, and it traps misaligned targets into a halt state. It sits between pc_gen/decode/ALU (redirect sources) and ifetch (PC consumer), and generalises the single-source PC mux to N sources with registered state.

---
 rtl/pc_redirect_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pc_redirect_ctrl.sv
// Front-end PC owner: advances the fetch PC, arbitrates NSRC stage redirects
// by age, drives flushes and the fetch epoch, and traps misaligned targets.
module pc_redirect_ctrl #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     NSRC     = 3,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     EPOCH_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [XLEN-1:0]      pc_o,
    output logic                 pc_valid_o,
    input  logic                 fetch_ready_i,
    input  logic [NSRC-1:0]      redir_valid_i,
    input  logic [NSRC*XLEN-1:0] redir_target_i,
    output logic [NSRC-1:0]      flush_o,
    output logic                 flush_if_o,
    output logic [EPOCH_W-1:0]   epoch_o,
    output logic                 misalign_o,
    output logic [XLEN-1:0]      badaddr_o,
    input  logic                 resume_i,
    input  logic [XLEN-1:0]      resume_pc_i
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } state_t;

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    state_t              state_q, state_d;
    logic [XLEN-1:0]     pc_q, pc_d;
    logic [EPOCH_W-1:0]  epoch_q, epoch_d;
    logic                misalign_q, misalign_d;
    logic [XLEN-1:0]     badaddr_q, badaddr_d;

    logic                win_any;
    logic [XLEN-1:0]     win_tgt;
    logic [NSRC-1:0]     flush_mask;

    // Oldest requesting stage wins: later loop iterations overwrite earlier.
    always_comb begin
        win_any = 1'b0;
        win_tgt = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (redir_valid_i[i]) begin
                win_any = 1'b1;
                win_tgt = redir_target_i[i*XLEN +: XLEN];
            end
        end
    end

    // Winner and every younger stage get flushed.
    always_comb begin
        logic acc;
        acc = 1'b0;
        flush_mask = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            acc = acc | redir_valid_i[i];
            flush_mask[i] = acc;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epoch_d    = epoch_q;
        misalign_d = misalign_q;
        badaddr_d  = badaddr_q;
        flush_o    = '0;
        flush_if_o = 1'b0;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (win_any) begin
                    flush_o    = flush_mask;
                    flush_if_o = 1'b1;
                    epoch_d    = epoch_q + EPOCH_W'(1);
                    if (win_tgt[1:0] == 2'b00) begin
                        pc_d = win_tgt;
                    end else begin
                        state_d    = HALT;
                        misalign_d = 1'b1;
                        badaddr_d  = win_tgt;
                    end
                end else if (fetch_ready_i) begin
                    pc_d = pc_q + XLEN'(4);
                end
            end
            HALT: begin
                if (resume_i) begin
                    state_d    = RUN;
                    pc_d       = resume_pc_i & ALIGN_MASK;
                    misalign_d = 1'b0;
                    epoch_d    = epoch_q + EPOCH_W'(1);
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
        if (!rst_n) begin
            flush_o    = '0;
            flush_if_o = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            epoch_q    <= '0;
            misalign_q <= 1'b0;
            badaddr_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epoch_q    <= epoch_d;
            misalign_q <= misalign_d;
            badaddr_q  <= badaddr_d;
        end
    end

    assign pc_o       = pc_q;
    assign pc_valid_o = (state_q == RUN);
    assign epoch_o    = epoch_q;
    assign misalign_o = misalign_q;
    assign badaddr_o  = badaddr_q;

endmodule
